reg_file_write_ctrl: RTL and testbench
======================================

Name: reg_file_write_ctrl

Overview:
- Write-port controller for the 8x8 register file.
- Arbitrates two writeback requesters (A: ALU writeback, B: load/immediate path) onto the file's single write port, using round-robin priority.
- Also sequences a software "clear all" that writes 0 to every register, one per cycle.
- Outputs drive the register file's IN, INADDRESS and WRITE directly; the file samples them on posedge CLK.

Parameters:
- DW, 8, data width of the register file.
- AW, 3, register address width.
- NREGS, 8, number of registers cleared by a clear sequence (2**AW).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- A_REQ  input  1  requester A has a write pending; held until A_ACK.
- A_ADDR  input  AW  requester A destination register.
- A_DATA  input  DW  requester A write data.
- A_ACK  output  1  one-cycle pulse: A's transaction captured.
- B_REQ, B_ADDR, B_DATA, B_ACK  same as A, for requester B.
- CLR_REQ  input  1  request to zero all registers; held until CLR_DONE.
- CLR_DONE  output  1  one-cycle pulse after the last clear write.
- WRITE  output  1  register file write enable.
- INADDRESS  output  AW  register file write address.
- IN  output  DW  register file write data.
- BUSY  output  1  high while in the CLEAR state.
- LAST_GNT  output  1  0 = A granted last, 1 = B granted last.

Behaviour:
- All outputs are registered. While RESET=0: WRITE=0, INADDRESS=0, IN=0, A_ACK=B_ACK=0, CLR_DONE=0, BUSY=0, LAST_GNT=1 (so A wins first), state=IDLE, clear counter=0.
- States: IDLE, CLEAR.
- IDLE, at each posedge, evaluate in priority order:
  - CLR_REQ=1 and CLR_DONE=0: go to CLEAR, counter=0.
  - Otherwise form eligible requests: A eligible = A_REQ & ~A_ACK; B eligible = B_REQ & ~B_ACK. The mask blocks re-granting a transaction already acked but not yet withdrawn.
  - One eligible: grant it.
  - Both eligible: grant the one not equal to LAST_GNT.
  - On grant: WRITE=1, INADDRESS/IN = the winner's ADDR/DATA, winner's ACK=1, LAST_GNT updated.
  - No grant: WRITE=0, both ACKs 0.
- Latency:
  - REQ sampled at edge k gives WRITE and ACK high in cycle k..k+1.
  - The register file commits the data at edge k+1.
  - The requester may drop REQ or present a new ADDR/DATA from cycle k+1.
- Throughput: one write per cycle total. A single requester with REQ held continuously gets a grant every other cycle, due to the ACK mask.
- CLEAR:
  - Each posedge drives WRITE=1, INADDRESS=counter, IN=0, BUSY=1, then counter+1.
  - After the edge that issues address NREGS-1: return to IDLE with WRITE=0, BUSY=0, CLR_DONE=1 for one cycle.
  - Exactly NREGS writes, addresses ascending 0..7. The counter is AW+1 bits wide so the terminal count is unambiguous.
- Clear vs requests:
  - A_REQ/B_REQ present during CLEAR are not acked; they stay pending and are serviced in IDLE after CLR_DONE.
  - If CLR_REQ and a write request arrive at the same edge in IDLE, CLEAR wins.
  - A write granted in the cycle before a clear starts has already committed; it is never aborted.
- CLR_REQ still high during the CLR_DONE cycle is ignored (masked). Holding it one further cycle starts a new clear.
- Reset mid-CLEAR: the sequence is aborted immediately, WRITE drops asynchronously, and no CLR_DONE is issued.
- Reset mid-grant: the ACK is lost. The requester must re-request after reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package (reg_file_ctrl_pkg):
  - state encoding localparams ST_IDLE/ST_CLEAR;
  - GNT_A=0 / GNT_B=1;
  - default DW/AW/NREGS constants for the CPU top.
- One sub-module, rr_arb2:
  - inputs: two request bits plus the last-grant bit;
  - outputs: one-hot grant plus the next last-grant value;
  - purely combinational; the parent registers the results.

Test Plan:
- Reset then A_REQ=1, A_ADDR=3, A_DATA=8'h5A for one transaction -> WRITE=1, INADDRESS=3, IN=5A, A_ACK=1 the cycle after sampling; register file reg3=5A after the following edge.
- A and B request together (A: r1=11, B: r2=22), both held until acked -> A granted first, then B the next cycle. On repeat contention: B first, A second (alternation).
- A_REQ held high with new ADDR/DATA supplied each time after ACK -> grants in alternate cycles only; no duplicate write of the same transaction.
- Preload regs 0..7 with 8'hFF, then pulse CLR_REQ until CLR_DONE -> 8 consecutive WRITE cycles, addresses 0..7, IN=0, BUSY high 8 cycles; CLR_DONE one cycle; all regs read 0.
- CLR_REQ and B_REQ (r5=77) at the same edge -> clear runs first, B_ACK held off, then r5 written 77 after CLR_DONE; final r5=77, others 0.
- Assert RESET=0 at counter=4 during a clear -> WRITE=0 immediately, no CLR_DONE; after release a new clear restarts at address 0.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package reg_file_ctrl_pkg;

  localparam int unsigned RF_DW    = 8;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned RF_NREGS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational, the parent registers the results.
module rr_arb2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_gnt,
  output logic [1:0] gnt_c,
  output logic       last_gnt_nxt_c
);

  import reg_file_ctrl_pkg::*;

  // A wins when alone or when B was granted last; B wins otherwise.
  always_comb begin
    gnt_c          = 2'b00;
    last_gnt_nxt_c = last_gnt;
    if (req_a && (!req_b || (last_gnt == GNT_B))) begin
      gnt_c          = 2'b01;
      last_gnt_nxt_c = GNT_A;
    end else if (req_b) begin
      gnt_c          = 2'b10;
      last_gnt_nxt_c = GNT_B;
    end
  end

endmodule

// File: rtl/reg_file_write_ctrl.sv
// Write-port controller for the register file: round-robin writeback
// arbitration between two requesters plus a sequenced clear-all.
module reg_file_write_ctrl #(
  parameter int unsigned DW    = reg_file_ctrl_pkg::RF_DW,
  parameter int unsigned AW    = reg_file_ctrl_pkg::RF_AW,
  parameter int unsigned NREGS = reg_file_ctrl_pkg::RF_NREGS
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          A_REQ,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_DATA,
  output logic          A_ACK,
  input  logic          B_REQ,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_DATA,
  output logic          B_ACK,
  input  logic          CLR_REQ,
  output logic          CLR_DONE,
  output logic          WRITE,
  output logic [AW-1:0] INADDRESS,
  output logic [DW-1:0] IN,
  output logic          BUSY,
  output logic          LAST_GNT
);

  import reg_file_ctrl_pkg::*;

  // One extra bit so the terminal count NREGS is distinct from address 0.
  localparam int unsigned CW = AW + 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          elig_a;
  logic          elig_b;
  logic [1:0]    gnt_c;
  logic          last_gnt_nxt_c;

  // A transaction already acked but not yet withdrawn must not be granted again.
  assign elig_a = A_REQ & ~A_ACK;
  assign elig_b = B_REQ & ~B_ACK;

  rr_arb2 u_arb (
    .req_a          (elig_a),
    .req_b          (elig_b),
    .last_gnt       (LAST_GNT),
    .gnt_c          (gnt_c),
    .last_gnt_nxt_c (last_gnt_nxt_c)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
      A_ACK     <= 1'b0;
      B_ACK     <= 1'b0;
      CLR_DONE  <= 1'b0;
      BUSY      <= 1'b0;
      LAST_GNT  <= GNT_B;
    end else begin
      WRITE    <= 1'b0;
      A_ACK    <= 1'b0;
      B_ACK    <= 1'b0;
      CLR_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A clear request lingering through its own CLR_DONE cycle is ignored.
          if (CLR_REQ && !CLR_DONE) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (gnt_c != 2'b00) begin
            WRITE     <= 1'b1;
            INADDRESS <= gnt_c[0] ? A_ADDR : B_ADDR;
            IN        <= gnt_c[0] ? A_DATA : B_DATA;
            A_ACK     <= gnt_c[0];
            B_ACK     <= gnt_c[1];
            LAST_GNT  <= last_gnt_nxt_c;
          end
        end
        ST_CLEAR: begin
          if (cnt == CW'(NREGS)) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            CLR_DONE <= 1'b1;
          end else begin
            WRITE     <= 1'b1;
            INADDRESS <= cnt[AW-1:0];
            IN        <= '0;
            BUSY      <= 1'b1;
            cnt       <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_write_ctrl.sv
// Directed bench for reg_file_write_ctrl with a write scoreboard and a
// behavioural register file fed from the controller outputs.
module tb_reg_file_write_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned NREGS = 8;
  localparam int SRC_A   = 0;
  localparam int SRC_B   = 1;
  localparam int SRC_CLR = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            src;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          CLK;
  logic          RESET;
  logic          A_REQ;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_DATA;
  logic          A_ACK;
  logic          B_REQ;
  logic [AW-1:0] B_ADDR;
  logic [DW-1:0] B_DATA;
  logic          B_ACK;
  logic          CLR_REQ;
  logic          CLR_DONE;
  logic          WRITE;
  logic [AW-1:0] INADDRESS;
  logic [DW-1:0] IN;
  logic          BUSY;
  logic          LAST_GNT;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  req_t a_pend[$];
  req_t b_pend[$];
  logic clr_want = 1'b0;
  logic [DW-1:0] rf     [NREGS];
  logic [DW-1:0] exp_rf [NREGS];

  reg_file_write_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .A_REQ     (A_REQ),
    .A_ADDR    (A_ADDR),
    .A_DATA    (A_DATA),
    .A_ACK     (A_ACK),
    .B_REQ     (B_REQ),
    .B_ADDR    (B_ADDR),
    .B_DATA    (B_DATA),
    .B_ACK     (B_ACK),
    .CLR_REQ   (CLR_REQ),
    .CLR_DONE  (CLR_DONE),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS),
    .IN        (IN),
    .BUSY      (BUSY),
    .LAST_GNT  (LAST_GNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file behaviour: commits IN at INADDRESS on the edge after WRITE.
  always @(posedge CLK) if (WRITE === 1'b1) rf[INADDRESS] <= IN;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    A_REQ = (a_pend.size() > 0);
    if (a_pend.size() > 0) begin
      A_ADDR = a_pend[0].addr;
      A_DATA = a_pend[0].data;
    end
    B_REQ = (b_pend.size() > 0);
    if (b_pend.size() > 0) begin
      B_ADDR = b_pend[0].addr;
      B_DATA = b_pend[0].data;
    end
    CLR_REQ = clr_want;
  endtask

  task automatic push(input int src, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    req_t r;
    e = '{addr: addr, data: data, src: src};
    r = '{addr: addr, data: data};
    sb.push_back(e);
    exp_rf[addr] = data;
    if (src == SRC_A) a_pend.push_back(r);
    if (src == SRC_B) b_pend.push_back(r);
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push(SRC_CLR, AW'(i), '0);
  endtask

  // One clock: sample outputs, score any write, then let requesters react.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (BUSY === 1'b1) busy_cnt++;
    if (CLR_DONE === 1'b1) done_cnt++;
    if (WRITE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(WRITE), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(INADDRESS), 32'(e.addr));
        chk("wr_data", 32'(IN), 32'(e.data));
        chk("wr_a_ack", 32'(A_ACK), 32'(e.src == SRC_A));
        chk("wr_b_ack", 32'(B_ACK), 32'(e.src == SRC_B));
        chk("wr_busy", 32'(BUSY), 32'(e.src == SRC_CLR));
      end
    end
    if (A_ACK === 1'b1 && a_pend.size() > 0) void'(a_pend.pop_front());
    if (B_ACK === 1'b1 && b_pend.size() > 0) void'(b_pend.pop_front());
    if (CLR_DONE === 1'b1) clr_want = 1'b0;
    drive_pins();
  endtask

  task automatic wait_quiet(input string tag, input int max);
    int n = 0;
    while ((sb.size() > 0 || a_pend.size() > 0 || b_pend.size() > 0 || clr_want) && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'(0));
    repeat (3) tick();
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < NREGS; i++) chk(tag, 32'(rf[i]), 32'(exp_rf[i]));
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    a_pend.delete();
    b_pend.delete();
    sb.delete();
    clr_want = 1'b0;
    drive_pins();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_write", 32'(WRITE), 32'(0));
    chk("rst_inaddress", 32'(INADDRESS), 32'(0));
    chk("rst_in", 32'(IN), 32'(0));
    chk("rst_a_ack", 32'(A_ACK), 32'(0));
    chk("rst_b_ack", 32'(B_ACK), 32'(0));
    chk("rst_clr_done", 32'(CLR_DONE), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_last_gnt", 32'(LAST_GNT), 32'(1));
    #2 RESET = 1'b1;
  endtask

  initial begin
    bit found;
    A_ADDR = '0;
    A_DATA = '0;
    B_ADDR = '0;
    B_DATA = '0;
    do_reset();

    // Single A write: WRITE/ACK the cycle after sampling, committed one edge later.
    push(SRC_A, 3'd3, 8'h5A);
    drive_pins();
    tick();
    chk("t1_a_ack", 32'(A_ACK), 32'(1));
    chk("t1_last_gnt", 32'(LAST_GNT), 32'(0));
    tick();
    chk("t1_rf3", 32'(rf[3]), 32'h5A);
    wait_quiet("t1_drain", 10);

    // Contention after reset: A first, then B.
    do_reset();
    push(SRC_A, 3'd1, 8'h11);
    push(SRC_B, 3'd2, 8'h22);
    drive_pins();
    wait_quiet("t2_drain", 10);
    chk("t2_last_gnt_b", 32'(LAST_GNT), 32'(1));
    push(SRC_A, 3'd7, 8'h33);
    drive_pins();
    wait_quiet("t2b_drain", 10);
    chk("t2b_last_gnt_a", 32'(LAST_GNT), 32'(0));
    // A was last, so under contention B wins first.
    push(SRC_B, 3'd2, 8'h44);
    push(SRC_A, 3'd1, 8'h55);
    drive_pins();
    wait_quiet("t2c_drain", 10);
    chk("t2c_rf1", 32'(rf[1]), 32'h55);
    chk("t2c_rf2", 32'(rf[2]), 32'h44);

    // A held high with fresh data after each ACK: writes on alternate cycles.
    push(SRC_A, 3'd4, 8'hA1);
    push(SRC_A, 3'd5, 8'hA2);
    push(SRC_A, 3'd6, 8'hA3);
    drive_pins();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_write_pattern", 32'(WRITE), 32'(i % 2 == 0));
    end
    wait_quiet("t3_drain", 10);

    // Preload all registers, then clear them.
    for (int i = 0; i < NREGS; i++) push(SRC_A, AW'(i), 8'hFF);
    drive_pins();
    wait_quiet("t4_preload_drain", 40);
    check_rf("t4_preload_rf");
    busy_cnt = 0;
    done_cnt = 0;
    push_clear(NREGS);
    clr_want = 1'b1;
    drive_pins();
    wait_quiet("t4_clear_drain", 30);
    chk("t4_busy_cycles", 32'(busy_cnt), 32'(8));
    chk("t4_done_pulses", 32'(done_cnt), 32'(1));
    check_rf("t4_clear_rf");

    // Clear and B request at the same edge: clear first, B after CLR_DONE.
    busy_cnt = 0;
    done_cnt = 0;
    push_clear(NREGS);
    push(SRC_B, 3'd5, 8'h77);
    clr_want = 1'b1;
    drive_pins();
    wait_quiet("t5_drain", 30);
    chk("t5_done_pulses", 32'(done_cnt), 32'(1));
    check_rf("t5_rf");

    // Reset while the clear is writing address 4, then a fresh clear.
    done_cnt = 0;
    push_clear(5);
    clr_want = 1'b1;
    drive_pins();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (WRITE === 1'b1 && INADDRESS == 3'd4) found = 1'b1;
    end
    chk("t6_reached_addr4", 32'(found), 32'(1));
    #2 RESET = 1'b0;
    #1;
    chk("t6_write_async_drop", 32'(WRITE), 32'(0));
    chk("t6_busy_async_drop", 32'(BUSY), 32'(0));
    clr_want = 1'b0;
    drive_pins();
    tick();
    tick();
    #2 RESET = 1'b1;
    tick();
    tick();
    chk("t6_no_done", 32'(done_cnt), 32'(0));
    chk("t6_last_gnt", 32'(LAST_GNT), 32'(1));
    push_clear(NREGS);
    clr_want = 1'b1;
    drive_pins();
    wait_quiet("t6_restart_drain", 30);
    chk("t6_done_pulses", 32'(done_cnt), 32'(1));
    check_rf("t6_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
